// File: rtl/sec_angle_dispatch.sv
// Secant LUT front/back end: reduces an angle mod 360, classifies the quadrant,
// drives the LUT and returns its result. Optional macro SEC_SIGN_FIX_EN forces the sign bit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module sec_angle_dispatch #(
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int LUT_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   angle_in,
    output logic                    lut_en,
    output logic [1:0]              lut_quadrant,
    output logic [DATA_WIDTH-1:0]   lut_angle,
    input  logic [2*DATA_WIDTH-1:0] lut_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    undefined
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE and then holds its data.

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_CLASSIFY,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int KW = $clog2(DATA_WIDTH);
    localparam logic [KW-1:0] K_START = KW'(DATA_WIDTH - 9);
    localparam logic [3:0] WAIT_LOAD = 4'(LUT_LATENCY);
    localparam logic [2*DATA_WIDTH-1:0] POS_INF = (2*DATA_WIDTH)'(64'h7FF0_0000_0000_0000);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   r;
    logic [KW-1:0]           k;
    logic [3:0]              wait_cnt;

    logic [DATA_WIDTH-1:0]   modulus;
    logic [1:0]              cls_quad;
    logic [DATA_WIDTH-1:0]   cls_ref;
    logic                    cls_undef;
    logic [2*DATA_WIDTH-1:0] captured;

    // 360<<k never overflows: 360 < 2^9 and k tops out at DATA_WIDTH-9.
    assign modulus = DATA_WIDTH'(360) << k;

    always_comb begin
        cls_quad  = 2'd0;
        cls_ref   = '0;
        cls_undef = 1'b0;
        if (r < DATA_WIDTH'(90)) begin
            cls_quad = 2'd0;
            cls_ref  = r;
        end else if (r == DATA_WIDTH'(90)) begin
            cls_undef = 1'b1;
        end else if (r <= DATA_WIDTH'(180)) begin
            cls_quad = 2'd1;
            cls_ref  = DATA_WIDTH'(180) - r;
        end else if (r < DATA_WIDTH'(270)) begin
            cls_quad = 2'd2;
            cls_ref  = r - DATA_WIDTH'(180);
        end else if (r == DATA_WIDTH'(270)) begin
            cls_undef = 1'b1;
        end else begin
            cls_quad = 2'd3;
            cls_ref  = DATA_WIDTH'(360) - r;
        end
    end

`ifdef SEC_SIGN_FIX_EN
    // Secant is negative in Q1 and Q2; the LUT supplies only the magnitude.
    assign captured = {(lut_quadrant == 2'd1) || (lut_quadrant == 2'd2),
                       lut_data[2*DATA_WIDTH-2:0]};
`else
    assign captured = lut_data;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            r            <= '0;
            k            <= '0;
            wait_cnt     <= '0;
            in_ready     <= 1'b1;
            lut_en       <= 1'b0;
            lut_quadrant <= 2'd0;
            lut_angle    <= '0;
            out_valid    <= 1'b0;
            result       <= '0;
            undefined    <= 1'b0;
        end else begin
            lut_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        r        <= angle_in;
                        k        <= K_START;
                        in_ready <= 1'b0;
                        state    <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    if (r >= modulus) begin
                        r <= r - modulus;
                    end
                    if (k == '0) begin
                        state <= S_CLASSIFY;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                S_CLASSIFY: begin
                    if (cls_undef) begin
                        undefined <= 1'b1;
                        result    <= POS_INF;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        lut_quadrant <= cls_quad;
                        lut_angle    <= cls_ref;
                        lut_en       <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        result    <= captured;
                        undefined <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sec_angle_dispatch.sv
// Bench for sec_angle_dispatch: random and directed angles, a LUT model, and a
// scoreboard that predicts quadrant/reference angle/result and handshake timing.
module tb_sec_angle_dispatch;

    localparam int DW      = 32;
    localparam int LAT     = 1;
    localparam int LAT_NRM = DW - 5 + LAT;
    localparam int LAT_UND = DW - 7;
    localparam int LUT_AT  = DW - 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] angle_in = '0;
    logic          lut_en;
    logic [1:0]    lut_quadrant;
    logic [DW-1:0] lut_angle;
    logic [2*DW-1:0] lut_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*DW-1:0] result;
    logic          undefined;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc = 0;
    int cur_lat = 0;
    bit busy = 1'b0;
    bit post_rst = 1'b0;
    int mode = 2;

    logic [64:0] exp_q[$];
    logic [33:0] exp_lut_q[$];

    sec_angle_dispatch #(.DATA_WIDTH(DW), .LUT_LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .angle_in(angle_in), .lut_en(lut_en), .lut_quadrant(lut_quadrant),
        .lut_angle(lut_angle), .lut_data(lut_data), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .undefined(undefined)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] lut_fn(input logic [1:0] q, input logic [31:0] a);
        if (a == 32'd0) return 64'h3FF0_0000_0000_0000;
        if (a == 32'd60) return 64'h4000_0000_0000_0000;
        return {q[0] ^ a[0], 11'h3FF, a[19:0], 30'd0, q};
    endfunction

    function automatic logic [63:0] exp_result(input logic [1:0] q, input logic [31:0] a);
        logic [63:0] v;
        v = lut_fn(q, a);
`ifdef SEC_SIGN_FIX_EN
        v[63] = (q == 2'd1) || (q == 2'd2);
`endif
        return v;
    endfunction

    // Angle in degrees -> quadrant and reference angle, straight from trigonometry.
    function automatic void ref_model(input logic [31:0] a, output logic [1:0] q,
                                      output logic [31:0] rf, output logic und);
        int unsigned r;
        r = a % 32'd360;
        und = (r == 90) || (r == 270);
        q = 2'd0;
        rf = 32'd0;
        if (r < 90) begin q = 2'd0; rf = r; end
        else if (r <= 180) begin q = 2'd1; rf = 180 - r; end
        else if (r < 270) begin q = 2'd2; rf = r - 180; end
        else begin q = 2'd3; rf = 360 - r; end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
    endtask

    // LUT model: data appears one edge after lut_en is sampled and holds.
    always @(posedge clk) if (lut_en) lut_data <= lut_fn(lut_quadrant, lut_angle);

    always @(posedge clk) begin
        #2;
        case (mode)
            0: out_ready = ($urandom_range(0, 2) != 0);
            1: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [1:0] q;
        logic [31:0] rf;
        logic und;
        logic [64:0] e;
        logic [33:0] el;
        if (!reset_n) begin
            exp_q.delete();
            exp_lut_q.delete();
            busy = 1'b0;
            post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                chk("rst_lut_en", 64'(lut_en), 64'd0);
                chk("rst_lut_quadrant", 64'(lut_quadrant), 64'd0);
                chk("rst_lut_angle", 64'(lut_angle), 64'd0);
                chk("rst_result", result, 64'd0);
                chk("rst_undefined", 64'(undefined), 64'd0);
                post_rst = 1'b0;
            end
            chk("in_ready", 64'(in_ready), 64'(!busy));
            chk("out_valid", 64'(out_valid), 64'(busy && (cyc - acc >= cur_lat)));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("result_unexpected");
                end else begin
                    e = exp_q[0];
                    chk("result", result, e[63:0]);
                    chk("undefined", 64'(undefined), 64'(e[64]));
                end
            end
            if (lut_en) begin
                if (exp_lut_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL lut_en_unexpected actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    el = exp_lut_q.pop_front();
                    chk("lut_quadrant", 64'(lut_quadrant), 64'(el[33:32]));
                    chk("lut_angle", 64'(lut_angle), 64'(el[31:0]));
                    chk("lut_en_timing", 64'(cyc - acc), 64'(LUT_AT));
                end
            end
            if (in_valid && in_ready) begin
                ref_model(angle_in, q, rf, und);
                if (und) begin
                    exp_q.push_back({1'b1, 64'h7FF0_0000_0000_0000});
                    cur_lat = LAT_UND;
                end else begin
                    exp_lut_q.push_back({q, rf});
                    exp_q.push_back({1'b0, exp_result(q, rf)});
                    cur_lat = LAT_NRM;
                end
                busy = 1'b1;
                acc = cyc + 1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] a);
        int t;
        t = 0;
        forever begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            angle_in = in_ready ? a : $urandom;
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 300) begin
                fail_now("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        angle_in = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i <= 300; i++) begin
            @(posedge clk);
            if (!busy) return;
        end
        fail_now("idle_timeout");
    endtask

    task automatic wait_valid();
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        fail_now("valid_timeout");
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        send(32'd0);
        wait_idle();
        send(32'd120);
        wait_idle();
        send(32'd90);
        send(32'd270);
        send(32'd750);
        send(32'hFFFF_FFFF);
        wait_idle();

        // Hold the result under back-pressure while a stray request is offered.
        mode = 1;
        send(32'd200);
        wait_valid();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        angle_in = 32'd33;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mode = 2;
        wait_idle();

        // Abort in REDUCE, then in WAIT.
        send(32'd500);
        repeat (9) @(posedge clk);
        #1;
        pulse_reset();
        send(32'd180);
        wait_idle();
        send(32'd45);
        repeat (26) @(posedge clk);
        #1;
        pulse_reset();
        send(32'd180);
        wait_idle();

        mode = 0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = $urandom_range(0, 719);
                2: a = 32'(360 * $urandom_range(0, 1000)) + ($urandom_range(0, 1) != 0 ? 32'd90 : 32'd270);
                default: a = 32'(360 * $urandom_range(0, 50) + 90 * $urandom_range(0, 3)
                                 + $urandom_range(0, 2)) - 32'd1;
            endcase
            send(a);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        mode = 2;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
